// File: rtl/tdoa_capture_pkg.sv
// Shared types and constants for the TDOA capture front end and the localizer
// that consumes its tau outputs.
package tdoa_capture_pkg;

    localparam int TAU_W    = 34;
    localparam int SAMPLE_W = 16;
    localparam int CNT_W    = 16;
    localparam int MAG_W    = SAMPLE_W + 1;
    // Q24 seconds per sample period at 48 kHz: round(2^24 / 48000)
    localparam int Q24_TICK = 350;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_COMPUTE,
        ST_DONE,
        ST_HOLDOFF
    } tdoa_state_e;

    // Signed sample-count difference scaled to Q24 seconds, TAU_W bits wide.
    function automatic logic signed [TAU_W-1:0] scale_delay(
        input logic [CNT_W-1:0]        ts_k,
        input logic [CNT_W-1:0]        ts_ref,
        input logic signed [TAU_W-1:0] tick
    );
        logic signed [TAU_W-1:0] diff;
        diff = $signed({{(TAU_W-CNT_W){1'b0}}, ts_k})
             - $signed({{(TAU_W-CNT_W){1'b0}}, ts_ref});
        return diff * tick;
    endfunction

endpackage

// File: rtl/tdoa_capture_onset_det.sv
// Per-microphone onset detector: 17-bit magnitude compared against a threshold,
// so -32768 maps to +32768 rather than wrapping.
module onset_det
    import tdoa_capture_pkg::*;
#(
    parameter int THRESH = 4096
) (
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic                       onset
);

    localparam logic [MAG_W-1:0] THRESH_V = MAG_W'(THRESH);

    logic [MAG_W-1:0] ext;
    logic [MAG_W-1:0] mag;

    always_comb begin
        ext = {sample[SAMPLE_W-1], sample};
        mag = sample[SAMPLE_W-1] ? (~ext + MAG_W'(1)) : ext;
    end

    assign onset = (mag >= THRESH_V);

endmodule

// File: rtl/tdoa_capture.sv
// Captures per-microphone onset sample times after a first onset and emits the
// arrival delays of mic1..mic3 relative to mic0 in signed Q24 seconds.
module tdoa_capture
    import tdoa_capture_pkg::*;
#(
    parameter int TICK_Q24 = Q24_TICK,
    parameter int THRESH   = 4096,
    parameter int MAX_WIN  = 64,
    parameter int HOLDOFF  = 2400
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic signed [SAMPLE_W-1:0] mic0,
    input  logic signed [SAMPLE_W-1:0] mic1,
    input  logic signed [SAMPLE_W-1:0] mic2,
    input  logic signed [SAMPLE_W-1:0] mic3,
    output logic signed [TAU_W-1:0]    tau1,
    output logic signed [TAU_W-1:0]    tau2,
    output logic signed [TAU_W-1:0]    tau3,
    output logic                       tau_valid,
    input  logic                       tau_ready,
    output logic                       timeout,
    output tdoa_state_e                dbg_state
);

    localparam logic signed [TAU_W-1:0] TICK_V    = TAU_W'(TICK_Q24);
    localparam logic [CNT_W-1:0]        WIN_V     = CNT_W'(MAX_WIN);
    localparam logic [CNT_W-1:0]        HOLD_LAST = CNT_W'(HOLDOFF - 1);

    tdoa_state_e      state;
    logic [3:0]       onset;
    logic [3:0]       seen;
    logic [CNT_W-1:0] ts [4];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    onset_det #(.THRESH(THRESH)) u_det0 (.sample(mic0), .onset(onset[0]));
    onset_det #(.THRESH(THRESH)) u_det1 (.sample(mic1), .onset(onset[1]));
    onset_det #(.THRESH(THRESH)) u_det2 (.sample(mic2), .onset(onset[2]));
    onset_det #(.THRESH(THRESH)) u_det3 (.sample(mic3), .onset(onset[3]));

    assign cnt_inc   = cnt + CNT_W'(1);
    assign dbg_state = state;

    // Output handshake: an event transfers on any clock where tau_valid && tau_ready;
    // tau_valid never depends on tau_ready and tau1..tau3 hold while tau_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            seen      <= '0;
            for (int k = 0; k < 4; k++) ts[k] <= '0;
            tau1      <= '0;
            tau2      <= '0;
            tau3      <= '0;
            tau_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sample_en && (|onset)) begin
                        state <= ST_CAPTURE;
                        cnt   <= '0;
                        for (int k = 0; k < 4; k++) begin
                            if (onset[k]) begin
                                ts[k]   <= '0;
                                seen[k] <= 1'b1;
                            end
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (&seen) begin
                        state <= ST_COMPUTE;
                    end else if (sample_en) begin
                        cnt <= cnt_inc;
                        for (int k = 0; k < 4; k++) begin
                            if (onset[k] && !seen[k]) begin
                                ts[k]   <= cnt_inc;
                                seen[k] <= 1'b1;
                            end
                        end
                        // A channel arriving on the window's last sample still completes the event.
                        if ((cnt_inc >= WIN_V) && !(&(seen | onset))) begin
                            state   <= ST_HOLDOFF;
                            timeout <= 1'b1;
                            cnt     <= '0;
                            seen    <= '0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    tau1      <= scale_delay(ts[1], ts[0], TICK_V);
                    tau2      <= scale_delay(ts[2], ts[0], TICK_V);
                    tau3      <= scale_delay(ts[3], ts[0], TICK_V);
                    tau_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (tau_ready) begin
                        tau_valid <= 1'b0;
                        state     <= ST_HOLDOFF;
                        cnt       <= '0;
                        seen      <= '0;
                    end
                end
                ST_HOLDOFF: begin
                    seen <= '0;
                    if (sample_en) begin
                        if (cnt >= HOLD_LAST) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdoa_capture.sv
// Directed bench for tdoa_capture: stimulus pushes expected events into a queue,
// a negedge monitor pops and compares on every transfer or timeout pulse.
module tb_tdoa_capture;
    import tdoa_capture_pkg::*;

    localparam int EW = 1 + 3 * TAU_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_en = 1'b0;
    logic sample_en2 = 1'b0;
    logic signed [SAMPLE_W-1:0] mic0 = '0, mic1 = '0, mic2 = '0, mic3 = '0;
    logic signed [TAU_W-1:0] tau1, tau2, tau3;
    logic tau_valid, timeout;
    logic tau_ready = 1'b1;
    tdoa_state_e dbg_state;

    logic signed [TAU_W-1:0] b_tau1, b_tau2, b_tau3;
    logic b_valid, b_timeout;
    tdoa_state_e dbg_state2;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic prev_valid = 1'b0;
    logic [3*TAU_W-1:0] prev_taus = '0;

    tdoa_capture dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
        .mic0(mic0), .mic1(mic1), .mic2(mic2), .mic3(mic3),
        .tau1(tau1), .tau2(tau2), .tau3(tau3),
        .tau_valid(tau_valid), .tau_ready(tau_ready), .timeout(timeout),
        .dbg_state(dbg_state)
    );

    tdoa_capture #(.THRESH(32768), .MAX_WIN(4), .HOLDOFF(2)) dut_full_scale (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en2),
        .mic0(mic0), .mic1(mic1), .mic2(mic2), .mic3(mic3),
        .tau1(b_tau1), .tau2(b_tau2), .tau3(b_tau3),
        .tau_valid(b_valid), .tau_ready(1'b1), .timeout(b_timeout),
        .dbg_state(dbg_state2)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] pack_exp(input logic is_to, input logic signed [TAU_W-1:0] a,
                                               input logic signed [TAU_W-1:0] b,
                                               input logic signed [TAU_W-1:0] c);
        return {is_to, a, b, c};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if ((tau_valid && tau_ready) || timeout) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got valid=%0b timeout=%0b with nothing expected",
                             tau_valid, timeout);
                end else begin
                    if (exp_q[0][EW-1] !== timeout ||
                        (!timeout && {tau1, tau2, tau3} !== exp_q[0][EW-2:0])) begin
                        errors++;
                        $display("FAIL event: got to=%0b tau=%0d,%0d,%0d expected to=%0b tau=%0d,%0d,%0d",
                                 timeout, tau1, tau2, tau3, exp_q[0][EW-1],
                                 $signed(exp_q[0][3*TAU_W-1:2*TAU_W]),
                                 $signed(exp_q[0][2*TAU_W-1:TAU_W]),
                                 $signed(exp_q[0][TAU_W-1:0]));
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (tau_valid && prev_valid) begin
                checks++;
                if ({tau1, tau2, tau3} !== prev_taus) begin
                    errors++;
                    $display("FAIL tau_stable: got %0h expected %0h", {tau1, tau2, tau3}, prev_taus);
                end
            end
            prev_valid <= tau_valid;
            prev_taus  <= {tau1, tau2, tau3};
        end
    end

    task automatic put_sample(input logic signed [15:0] a, input logic signed [15:0] b,
                              input logic signed [15:0] c, input logic signed [15:0] d);
        mic0 = a; mic1 = b; mic2 = c; mic3 = d;
        sample_en = 1'b1;
        @(posedge clk); #1;
        sample_en = 1'b0;
        @(posedge clk); #1;
    endtask

    // Channel k sits just below threshold until sample tk, then above (tk < 0: never).
    task automatic run_event(input int t0, input int t1, input int t2, input int t3, input int nsamp);
        for (int n = 0; n < nsamp; n++) begin
            put_sample((t0 >= 0 && n >= t0) ? 16'sd10000  : 16'sd100,
                       (t1 >= 0 && n >= t1) ? 16'sd12000  : -16'sd4095,
                       (t2 >= 0 && n >= t2) ? -16'sd20000 : 16'sd4095,
                       (t3 >= 0 && n >= t3) ? 16'sd4096   : -16'sd200);
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) put_sample(16'sd0, 16'sd0, 16'sd0, 16'sd0);
    endtask

    initial begin
        #12;
        check("reset_tau1", 128'(tau1), 128'(0));
        check("reset_valid", 128'(tau_valid), 128'(0));
        check("reset_timeout", 128'(timeout), 128'(0));
        check("reset_state", 128'(dbg_state), 128'(ST_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-scale threshold boundary on a second instance
        mic0 = 16'sd32767; mic1 = '0; mic2 = '0; mic3 = '0;
        sample_en2 = 1'b1; @(posedge clk); #1; sample_en2 = 1'b0;
        check("fullscale_pos_no_onset", 128'(dbg_state2), 128'(ST_IDLE));
        mic0 = -16'sd32768;
        sample_en2 = 1'b1; @(posedge clk); #1; sample_en2 = 1'b0;
        check("fullscale_neg_onset", 128'(dbg_state2), 128'(ST_CAPTURE));
        mic0 = '0;
        @(posedge clk); #1;

        // Positive delays, ready held high
        tau_ready = 1'b1;
        exp_q.push_back(pack_exp(1'b0, 34'sd1050, 34'sd1750, 34'sd0));
        run_event(0, 3, 5, 0, 6);
        quiet(2410);

        // Negative delays
        exp_q.push_back(pack_exp(1'b0, -34'sd1400, 34'sd0, 34'sd700));
        run_event(4, 0, 4, 6, 7);
        quiet(2410);

        // Stalled consumer with further onsets during DONE
        tau_ready = 1'b0;
        exp_q.push_back(pack_exp(1'b0, -34'sd350, 34'sd350, 34'sd700));
        run_event(1, 0, 2, 3, 4);
        check("latency_not_early", 128'(tau_valid), 128'(0));
        @(posedge clk); #1;
        check("latency_two_clocks", 128'(tau_valid), 128'(1));
        for (int i = 0; i < 5; i++) begin
            put_sample(16'sd30000, -16'sd30000, 16'sd30000, -16'sd30000);
            check("valid_held_in_done", 128'(tau_valid), 128'(1));
        end
        tau_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drops_after_xfer", 128'(tau_valid), 128'(0));
        quiet(2410);

        // Window expiry: mic3 never crosses
        exp_q.push_back(pack_exp(1'b1, 34'sd0, 34'sd0, 34'sd0));
        run_event(0, 0, 0, -1, 65);
        check("timeout_to_holdoff", 128'(dbg_state), 128'(ST_HOLDOFF));
        quiet(2000);
        put_sample(16'sd20000, 16'sd20000, 16'sd20000, 16'sd20000);
        quiet(500);
        check("holdoff_back_idle", 128'(dbg_state), 128'(ST_IDLE));
        exp_q.push_back(pack_exp(1'b0, -34'sd700, -34'sd350, 34'sd0));
        run_event(2, 0, 1, 2, 3);
        quiet(2410);

        // Asynchronous reset mid-capture
        run_event(0, 0, -1, -1, 2);
        check("pre_reset_capture", 128'(dbg_state), 128'(ST_CAPTURE));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", 128'(dbg_state), 128'(ST_IDLE));
        check("async_rst_tau1", 128'(tau1), 128'(0));
        check("async_rst_tau2", 128'(tau2), 128'(0));
        check("async_rst_valid", 128'(tau_valid), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_release_idle", 128'(dbg_state), 128'(ST_IDLE));
        exp_q.push_back(pack_exp(1'b0, 34'sd350, 34'sd700, 34'sd1050));
        run_event(0, 1, 2, 3, 4);
        quiet(20);

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
